// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared defines for the five-stage core pipeline control:
//                bus types, stage indices, FSM encoding, stall/flush patterns.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Instruction address bus and reset polarity shared across the core
  typedef logic [31:0] InstAddrBus;
  localparam logic RstEnable = 1'b1;

  // Per-stage hold/bubble enable bus
  typedef logic [5:0] StallBus;

  // Bit positions in StallBus: the register each bit controls
  localparam int STG_PC  = 0;  // PC register
  localparam int STG_IF  = 1;  // if_id
  localparam int STG_ID  = 2;  // id_ex
  localparam int STG_EX  = 3;  // ex_mem
  localparam int STG_MEM = 4;  // mem_wb
  localparam int STG_WB  = 5;  // reserved, never driven

  // Controller states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } pipe_state_e;

  // Hold patterns: every register upstream of the requester is frozen
  localparam StallBus STALL_MEM = 6'b011111;
  localparam StallBus STALL_EX  = 6'b001111;
  localparam StallBus STALL_ID  = 6'b000111;

  // An exception kills everything younger than MEM
  localparam StallBus FLUSH_EXCP = 6'b011110;

  // Redirect bubble counter width (REDIRECT_BUBBLES is 1..7)
  localparam int BUBBLE_W = 3;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Handshake bundle between the pipeline datapath (master) and
//                the pipeline control unit (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  // Requests from the datapath
  logic       stallreq_id;
  logic       stallreq_ex;
  logic       stallreq_mem;
  logic       branch_i;
  InstAddrBus branch_target_i;
  logic       excp_i;
  InstAddrBus excp_vector_i;

  // Controls back to the datapath
  StallBus    stall;
  StallBus    flush;
  logic       pc_load;
  InstAddrBus new_pc;
  logic       stall_timeout;
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output branch_i, branch_target_i, excp_i, excp_vector_i,
    input  stall, flush, pc_load, new_pc,
    input  stall_timeout, perf_stall_cycles, perf_flush_count
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  branch_i, branch_target_i, excp_i, excp_vector_i,
    output stall, flush, pc_load, new_pc,
    output stall_timeout, perf_stall_cycles, perf_flush_count
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; clr has priority over inc.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Count up on inc, hold at all-ones, clear on clr or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline control unit. Resolves stall, branch and exception
//                requests into per-stage hold/bubble enables and a PC load,
//                with a stall watchdog and saturating performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL        = 64,
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int                  CNT_W       = $clog2(MAX_STALL) + 1;
  localparam logic [CNT_W-1:0]    STALL_LIMIT = CNT_W'(MAX_STALL - 1);
  localparam logic [BUBBLE_W-1:0] BUBBLE_LOAD = BUBBLE_W'(REDIRECT_BUBBLES);

  pipe_state_e          state_q, state_d;
  logic [BUBBLE_W-1:0]  bubble_q, bubble_d;
  logic                 timeout_q;

  StallBus              stall_w;
  StallBus              flush_w;
  logic                 pc_load_w;
  InstAddrBus           new_pc_w;
  logic                 any_stall_w;
  logic [CNT_W-1:0]     stall_cnt_w;
  logic [31:0]          perf_stall_w;
  logic [15:0]          perf_flush_w;

  // Priority decode: reset > exception > redirect bubbles > mem > ex > id > branch
  always_comb begin
    stall_w   = '0;
    flush_w   = '0;
    pc_load_w = 1'b0;
    new_pc_w  = '0;
    state_d   = state_q;
    bubble_d  = bubble_q;
    if (rst == RstEnable) begin
      state_d  = ST_RUN;
      bubble_d = '0;
    end else if (bus.excp_i) begin
      flush_w   = FLUSH_EXCP;
      pc_load_w = 1'b1;
      new_pc_w  = bus.excp_vector_i;
      state_d   = ST_REDIRECT;
      bubble_d  = BUBBLE_LOAD;
    end else if (state_q == ST_REDIRECT) begin
      // Requesters were flushed by the exception, so their requests are stale
      flush_w[STG_IF] = 1'b1;
      bubble_d        = bubble_q - BUBBLE_W'(1);
      if (bubble_q <= BUBBLE_W'(1)) begin
        state_d = ST_RUN;
      end
    end else if (bus.stallreq_mem) begin
      stall_w = STALL_MEM;
      state_d = ST_STALL;
    end else if (bus.stallreq_ex) begin
      stall_w          = STALL_EX;
      flush_w[STG_MEM] = 1'b1;
      state_d          = ST_STALL;
    end else if (bus.stallreq_id) begin
      stall_w         = STALL_ID;
      flush_w[STG_EX] = 1'b1;
      state_d         = ST_STALL;
    end else begin
      state_d = ST_RUN;
      if (bus.branch_i) begin
        pc_load_w       = 1'b1;
        new_pc_w        = bus.branch_target_i;
        flush_w[STG_IF] = 1'b1;
      end
    end
  end

  // Controller state and redirect bubble counter
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= ST_RUN;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
    end
  end

  assign any_stall_w = |stall_w;

  // Consecutive-stall length; any unstalled cycle restarts it
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (any_stall_w),
    .clr_i   (~any_stall_w),
    .count_o (stall_cnt_w)
  );

  // Sticky watchdog: set once a stall run reaches MAX_STALL cycles
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      timeout_q <= 1'b0;
    end else if (any_stall_w && (stall_cnt_w >= STALL_LIMIT)) begin
      timeout_q <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(32)) u_perf_stall (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_w[STG_PC]),
    .clr_i   (1'b0),
    .count_o (perf_stall_w)
  );

  sat_counter #(.WIDTH(16)) u_perf_flush (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (pc_load_w),
    .clr_i   (1'b0),
    .count_o (perf_flush_w)
  );

  assign bus.stall             = stall_w;
  assign bus.flush             = flush_w;
  assign bus.pc_load           = pc_load_w;
  assign bus.new_pc            = new_pc_w;
  assign bus.stall_timeout     = timeout_q;
  assign bus.perf_stall_cycles = perf_stall_w;
  assign bus.perf_flush_count  = perf_flush_w;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. Collects stall requests from ID/EX/MEM, branch redirects from ID and exception redirects from MEM. Drives per-stage stall and flush enables into the PC register and the if_id / id_ex / ex_mem / mem_wb pipeline registers, plus the PC load path. Also maintains a stall watchdog and saturating performance counters.

## Interface

Parameters:
- MAX_STALL, 64: consecutive stalled cycles that set stall_timeout.
- REDIRECT_BUBBLES, 1: cycles of IF flush after an exception redirect (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stallreq_id  in  1  load-use hazard in ID
- stallreq_ex  in  1  multi-cycle op busy in EX
- stallreq_mem  in  1  data memory wait in MEM
- branch_i  in  1  taken branch/jump resolved in ID
- branch_target_i  in  32  branch target (`InstAddrBus`)
- excp_i  in  1  exception/eret taken in MEM (single-cycle pulse)
- excp_vector_i  in  32  handler or return address
- stall  out  6  hold enables: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved (0)
- flush  out  6  bubble-insert enables, same indexing; [0] and [5] always 0
- pc_load  out  1  PC takes new_pc at next edge
- new_pc  out  32  redirect address
- stall_timeout  out  1  sticky watchdog flag
- perf_stall_cycles  out  32  saturating count of stalled cycles
- perf_flush_count  out  16  saturating count of redirects

## Operation

- FSM states: RUN, STALL, REDIRECT. Reset state is RUN.
- Priority, evaluated combinationally each cycle from the current state and inputs: excp_i > stallreq_mem > stallreq_ex > stallreq_id > branch_i.
- **excp_i, any state:**
  - flush = 6'b011110, stall = 0.
  - pc_load = 1, new_pc = excp_vector_i.
  - Next state is REDIRECT; bubble counter loads REDIRECT_BUBBLES.
- **REDIRECT:**
  - flush = 6'b000010, stall = 0, pc_load = 0.
  - All stall requests and branch_i are ignored, because the requesting instructions are already flushed.
  - Bubble counter decrements each cycle; at 1 the next state is RUN.
  - A new excp_i reloads the counter.
- **Stall patterns:**
  - stallreq_mem: stall = 6'b011111, flush = 0.
  - stallreq_ex: stall = 6'b001111, flush[4] = 1.
  - stallreq_id: stall = 6'b000111, flush[3] = 1.
  - Any stall: next state is STALL, and branch_i is ignored with pc_load = 0 (ID re-presents the branch).
- **No stall request:** next state is RUN.
- **branch_i, no stall, not REDIRECT:** pc_load = 1, new_pc = branch_target_i, flush[1] = 1 (kills the wrong-path fetch).
- **Idle:** new_pc = 0 whenever pc_load = 0.
- **Watchdog:**
  - stall_cnt (registered) increments on each cycle where any stall bit is set, and clears on any cycle with stall = 0.
  - When stall_cnt reaches MAX_STALL-1 while stalled, stall_timeout sets and stays set until rst.
  - stall_cnt saturates rather than wrapping.
- **Performance counters:**
  - perf_stall_cycles increments on each cycle with stall[0] = 1.
  - perf_flush_count increments on each cycle with pc_load = 1.
  - Both saturate at all-ones.

## Timing

- stall, flush, pc_load and new_pc are combinational from inputs and state, with zero latency, so the pipeline registers act on the same edge.
- State, bubble counter, stall_cnt, stall_timeout and the perf counters are registered.
- **Reset:**
  - Registered state: state = RUN, counters = 0, stall_timeout = 0.
  - Outputs in the reset cycle are forced to stall = 0, flush = 0, pc_load = 0, new_pc = 0 regardless of inputs.
  - Reset mid-REDIRECT or mid-STALL returns to RUN on the next edge.
- **Simultaneous events:**
  - excp_i with any stall request: the exception wins and the stall count is cleared.
  - branch_i with excp_i: the exception wins.

## Structure

- Add to shared defines:
  - stage index constants (STG_PC..STG_WB);
  - state encodings;
  - StallBus (5:0).
- Reuse `InstAddrBus` and `RstEnable`.
- One sub-module, sat_counter (parameter WIDTH; inputs inc and clr; saturating). It is instantiated for stall_cnt and both perf counters.

## Test plan

- Reset with stallreq_mem = 1 and excp_i = 1 held: outputs all 0 during reset; after release, perf_stall_cycles = 0, stall_timeout = 0.
- stallreq_ex for 3 cycles, then released: stall = 6'b001111 and flush = 6'b010000 for 3 cycles; state STALL → RUN; perf_stall_cycles = 3.
- branch_i with target 0x0000_0040 and no stall: pc_load = 1, new_pc = 0x40, flush = 6'b000010. Repeat with stallreq_id = 1: pc_load = 0, stall = 6'b000111, flush = 6'b001000.
- excp_i with vector 0x0000_0020 while stallreq_mem = 1: flush = 6'b011110, stall = 0, new_pc = 0x20. Next cycle (REDIRECT_BUBBLES = 1): flush = 6'b000010, ignoring stallreq_id = 1; then RUN.
- MAX_STALL = 4 with stallreq_id held 4 cycles: stall_timeout rises after the 4th stalled edge and stays 1 after release.
- Force perf_flush_count to 16'hFFFE, then issue 3 branches: count holds at 16'hFFFF.
